// File: rtl/ctr_stream_engine.sv
// ctr_stream_engine: AES-256 counter-mode block stream engine with an
// iterative AES-256 encryption core (encryptiontop).
// One keystream block is generated per message block; din XOR keystream
// is presented on dout. Encrypt and decrypt are the same operation.
// Optional feature macro: CTR_OVERFLOW_ERR_EN. When it is defined, a counter
// wrap with blocks still remaining ends the message early and raises err.
// When it is undefined, the counter wraps silently and err is tied low.

// Iterative AES-256 encryptor: one round per cycle, round keys expanded
// on the fly. Starts on a rising edge of enable; pulses cipher_counter_o
// for one cycle when ciphertext is valid.
module encryptiontop (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [127:0] plaintext,
   input  logic [255:0] key_i,
   output logic [127:0] ciphertext,
   output logic         cipher_counter_o
);
   logic [127:0] st_q, st_d;
   logic [127:0] rk_prev_q, rk_prev_d;
   logic [127:0] rk_cur_q, rk_cur_d;
   logic [127:0] ct_q, ct_d;
   logic [3:0]   round_q, round_d;
   logic         run_q, run_d;
   logic         en_prev_q, en_prev_d;
   logic         pulse_q, pulse_d;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box computed as the GF(2^8) inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] b;
      sq = a;
      b  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gmul(sq, sq);
         b  = gmul(b, sq);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
             {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // SubBytes, ShiftRows and (except in the last round) MixColumns
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++)
            t[rr+4*c] = b[rr + 4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
         a0 = t[4*c];
         a1 = t[4*c+1];
         a2 = t[4*c+2];
         a3 = t[4*c+3];
         if (last) begin
            r[127-32*c -: 32] = {a0, a1, a2, a3};
         end else begin
            r[127-32*c -: 8]  = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
         end
      end
      return r;
   endfunction

   // Next AES-256 round key from the previous two; rot selects the
   // RotWord+Rcon step used for even-numbered round keys
   function automatic logic [127:0] next_rk(input logic [127:0] prev, input logic [127:0] cur,
                                            input logic rot, input logic [7:0] rcon);
      logic [31:0] t;
      logic [31:0] w0, w1, w2, w3;
      t = cur[31:0];
      if (rot) t = {t[23:0], t[31:24]};
      t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      if (rot) t[31:24] = t[31:24] ^ rcon;
      w0 = prev[127:96] ^ t;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = prev[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Round sequencing: initial AddRoundKey on start, then rounds 1..14
   always_comb begin
      st_d      = st_q;
      rk_prev_d = rk_prev_q;
      rk_cur_d  = rk_cur_q;
      ct_d      = ct_q;
      round_d   = round_q;
      run_d     = run_q;
      pulse_d   = 1'b0;
      en_prev_d = enable;
      if (run_q) begin
         st_d      = aes_round(st_q, round_q == 4'd14) ^ rk_cur_q;
         rk_prev_d = rk_cur_q;
         rk_cur_d  = next_rk(rk_prev_q, rk_cur_q, round_q[0], 8'h01 << round_q[3:1]);
         round_d   = round_q + 4'd1;
         if (round_q == 4'd14) begin
            ct_d    = st_d;
            run_d   = 1'b0;
            pulse_d = 1'b1;
         end
      end else if (enable && !en_prev_q) begin
         st_d      = plaintext ^ key_i[255:128];
         rk_prev_d = key_i[255:128];
         rk_cur_d  = key_i[127:0];
         round_d   = 4'd1;
         run_d     = 1'b1;
      end
   end

   // Core state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q      <= '0;
         rk_prev_q <= '0;
         rk_cur_q  <= '0;
         ct_q      <= '0;
         round_q   <= '0;
         run_q     <= 1'b0;
         en_prev_q <= 1'b0;
         pulse_q   <= 1'b0;
      end else begin
         st_q      <= st_d;
         rk_prev_q <= rk_prev_d;
         rk_cur_q  <= rk_cur_d;
         ct_q      <= ct_d;
         round_q   <= round_d;
         run_q     <= run_d;
         en_prev_q <= en_prev_d;
         pulse_q   <= pulse_d;
      end
   end

   assign ciphertext       = ct_q;
   assign cipher_counter_o = pulse_q;
endmodule

module ctr_stream_engine #(
   parameter int CTR_W      = 32,
   parameter int MAX_BLOCKS = 16,
   parameter int LEN_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [255:0]     key,
   input  logic [127:0]     iv,
   input  logic [LEN_W-1:0] nblocks,
   input  logic             din_valid,
   input  logic [127:0]     din,
   output logic             din_ready,
   output logic             dout_valid,
   output logic [127:0]     dout,
   input  logic             dout_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);
   typedef enum logic [2:0] {IDLE, GEN, KS_RDY, OUT, FIN} state_t;

   // Bits of the counter block that increment; the rest never change
   localparam logic [127:0]     LOW_MASK = (CTR_W >= 128) ? {128{1'b1}}
                                                          : ((128'd1 << CTR_W) - 128'd1);
   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BLOCKS);

   state_t             state_q, state_d;
   logic [255:0]       key_q, key_d;
   logic [127:0]       ctr_q, ctr_d;
   logic [127:0]       ks_q, ks_d;
   logic [127:0]       dout_q, dout_d;
   logic [LEN_W-1:0]   remain_q, remain_d;
   logic [LEN_W-1:0]   n_clamped;
   logic [127:0]       ctr_inc;
   logic               core_en;
   logic [127:0]       core_ct;
   logic               core_pulse;
`ifdef CTR_OVERFLOW_ERR_EN
   logic               err_q, err_d;
   logic               low_full;
`endif

   assign n_clamped = (nblocks > MAX_LEN) ? MAX_LEN : nblocks;
   assign ctr_inc   = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);

   encryptiontop u_core (
      .clk              (clk),
      .rst              (rst),
      .enable           (core_en),
      .plaintext        (ctr_q),
      .key_i            (key_q),
      .ciphertext       (core_ct),
      .cipher_counter_o (core_pulse)
   );

`ifdef CTR_OVERFLOW_ERR_EN
   assign low_full = ((ctr_q & LOW_MASK) == LOW_MASK);
`endif

   // Next-state, datapath updates and state-decoded outputs
   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      ctr_d      = ctr_q;
      ks_d       = ks_q;
      dout_d     = dout_q;
      remain_d   = remain_q;
`ifdef CTR_OVERFLOW_ERR_EN
      err_d      = err_q;
`endif
      busy       = 1'b1;
      done       = 1'b0;
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      core_en    = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               key_d    = key;
               ctr_d    = iv;
               remain_d = n_clamped;
`ifdef CTR_OVERFLOW_ERR_EN
               err_d    = 1'b0;
`endif
               state_d  = (n_clamped == '0) ? FIN : GEN;
            end
         end
         GEN: begin
            core_en = 1'b1;
            if (core_pulse) begin
               ks_d    = core_ct;
               state_d = KS_RDY;
            end
         end
         KS_RDY: begin
            din_ready = 1'b1;
            if (din_valid) begin
               dout_d  = din ^ ks_q;
               state_d = OUT;
            end
         end
         OUT: begin
            dout_valid = 1'b1;
            if (dout_ready) begin
               ctr_d    = ctr_inc;
               remain_d = remain_q - LEN_W'(1);
               if (remain_q == LEN_W'(1)) begin
                  state_d = FIN;
`ifdef CTR_OVERFLOW_ERR_EN
               end else if (low_full) begin
                  err_d   = 1'b1;
                  state_d = FIN;
`endif
               end else begin
                  state_d = GEN;
               end
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Engine registers; reset wins over every handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         key_q    <= '0;
         ctr_q    <= '0;
         ks_q     <= '0;
         dout_q   <= '0;
         remain_q <= '0;
`ifdef CTR_OVERFLOW_ERR_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         ctr_q    <= ctr_d;
         ks_q     <= ks_d;
         dout_q   <= dout_d;
         remain_q <= remain_d;
`ifdef CTR_OVERFLOW_ERR_EN
         err_q    <= err_d;
`endif
      end
   end

   assign dout = dout_q;
`ifdef CTR_OVERFLOW_ERR_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ctr_stream_engine.sv
// Scoreboard testbench for ctr_stream_engine: stimulus pushes expected
// dout blocks into a queue, a monitor pops and compares on each transfer.
module tb_ctr_stream_engine;
   localparam logic [255:0] KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
   localparam logic [127:0] CT1 = 128'h601ec313775789a5b7a7f504bbf3d228;
   localparam logic [127:0] CT2 = 128'hf443e3ca4d62b59aca84e990cacaf5c5;
   localparam logic [127:0] WIV      = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
   localparam logic [127:0] WIV_WRAP = 128'hf0f1f2f3f4f5f6f7f8f9fafb00000000;

   localparam logic [2047:0] SBOX_V = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [255:0] key = '0;
   logic [127:0] iv = '0;
   logic [4:0]   nblocks = '0;
   logic         din_valid = 1'b0;
   logic [127:0] din = '0;
   logic         din_ready;
   logic         dout_valid;
   logic [127:0] dout;
   logic         dout_ready = 1'b1;
   logic         busy, done, err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int en_cnt = 0;
   int xfer_cnt = 0;
   logic [127:0] exp_q [$];

   ctr_stream_engine #(.CTR_W(32), .MAX_BLOCKS(16), .LEN_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv), .nblocks(nblocks),
      .din_valid(din_valid), .din(din), .din_ready(din_ready),
      .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Reference AES-256 (table S-box, full key schedule)
   function automatic logic [7:0] sb(input logic [7:0] x);
      return SBOX_V[2047-8*x -: 8];
   endfunction
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [127:0] aes256(input logic [255:0] k, input logic [127:0] pt);
      logic [31:0]  w [60];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] o;
      for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         tmp = w[i-1];
         if (i % 8 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb(tmp[31:24]) ^ rc, sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])};
            rc  = xt(rc);
         end else if (i % 8 == 4) begin
            tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])};
         end
         w[i] = w[i-8] ^ tmp;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= 14; rnd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sb(s[r][(c+r)%4]);
         for (int c = 0; c < 4; c++) begin
            if (rnd == 14) begin
               for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
            end else begin
               s[0][c] = xt(t[0][c]) ^ xt(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
               s[1][c] = t[0][c] ^ xt(t[1][c]) ^ xt(t[2][c]) ^ t[2][c] ^ t[3][c];
               s[2][c] = t[0][c] ^ t[1][c] ^ xt(t[2][c]) ^ xt(t[3][c]) ^ t[3][c];
               s[3][c] = xt(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ xt(t[3][c]);
            end
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
         end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(4*c+r) -: 8] = s[r][c];
      return o;
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", name, got, req);
      end
   endtask

   // Monitor: one line per accepted output block, compared against the queue
   initial begin
      logic [127:0] e;
      forever begin
         @(negedge clk);
         if (!rst && dout_valid && dout_ready) begin
            xfer_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL dout_unexpected got %h required no block", dout);
            end else begin
               e = exp_q.pop_front();
               if (dout !== e) begin
                  errors++;
                  $display("FAIL dout got %h required %h", dout, e);
               end else begin
                  $display("xfer %0d dout %h ok", xfer_cnt, dout);
               end
            end
         end
      end
   end

   // Event counters for done pulses and core enable cycles
   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (dut.core_en) en_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1);
   end

   task automatic do_start(input logic [127:0] v_iv, input logic [4:0] n);
      @(posedge clk); #1;
      start = 1'b1; key = KEY; iv = v_iv; nblocks = n;
      @(posedge clk); #1;
      start = 1'b0;
      $display("start iv %h nblocks %0d", v_iv, n);
   endtask

   task automatic send_block(input logic [127:0] d, input logic [127:0] e);
      int cnt;
      exp_q.push_back(e);
      din = d;
      din_valid = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (!din_ready && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      check("din_ready_wait", {127'd0, din_ready}, 128'd1);
      @(posedge clk); #1;
      din_valid = 1'b0;
      din = '0;
   endtask

   task automatic wait_done(input int d0, input string tag);
      int cnt;
      cnt = 0;
      while (done_cnt == d0 && cnt < 600) begin
         @(negedge clk);
         cnt++;
      end
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'd1);
      check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      int d0, e0, x0;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_done", {127'd0, done}, 128'd0);
      check("rst_err", {127'd0, err}, 128'd0);
      check("rst_din_ready", {127'd0, din_ready}, 128'd0);
      check("rst_dout_valid", {127'd0, dout_valid}, 128'd0);
      check("rst_dout", dout, 128'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Known-answer encrypt
      d0 = done_cnt;
      do_start(IV, 5'd2);
      check("busy_after_start", {127'd0, busy}, 128'd1);
      send_block(PT1, CT1);
      send_block(PT2, CT2);
      wait_done(d0, "enc");
      check("enc_err", {127'd0, err}, 128'd0);

      // Decrypt returns the plaintext
      d0 = done_cnt;
      do_start(IV, 5'd2);
      send_block(CT1, PT1);
      send_block(CT2, PT2);
      wait_done(d0, "dec");

      // Zero-length message: done right away, no core activity
      d0 = done_cnt;
      e0 = en_cnt;
      do_start(IV, 5'd0);
      @(negedge clk);
      check("nb0_done", {127'd0, done}, 128'd1);
      @(negedge clk);
      check("nb0_done_low", {127'd0, done}, 128'd0);
      check("nb0_idle", {127'd0, busy}, 128'd0);
      check("nb0_core_en", 128'(en_cnt - e0), 128'd0);
      check("nb0_pulses", 128'(done_cnt - d0), 128'd1);

      // Backpressure for 20 cycles, with a start pulse that must be ignored
      d0 = done_cnt;
      x0 = xfer_cnt;
      dout_ready = 1'b0;
      do_start(IV, 5'd1);
      send_block(PT1, CT1);
      start = 1'b1; nblocks = 5'd0; iv = '1;
      @(posedge clk); #1 start = 1'b0;
      e0 = en_cnt;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("bp_dout_stable", dout, CT1);
         check("bp_dout_valid", {127'd0, dout_valid}, 128'd1);
      end
      check("bp_core_en", 128'(en_cnt - e0), 128'd0);
      check("bp_no_xfer", 128'(xfer_cnt - x0), 128'd0);
      @(posedge clk); #1 dout_ready = 1'b1;
      wait_done(d0, "bp");
      check("bp_one_xfer", 128'(xfer_cnt - x0), 128'd1);

      // Reset while generating, then a clean message
      do_start(IV, 5'd2);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mrst_busy", {127'd0, busy}, 128'd0);
      check("mrst_done", {127'd0, done}, 128'd0);
      check("mrst_din_ready", {127'd0, din_ready}, 128'd0);
      check("mrst_dout_valid", {127'd0, dout_valid}, 128'd0);
      check("mrst_dout", dout, 128'd0);
      check("mrst_err", {127'd0, err}, 128'd0);
      e0 = en_cnt;
      repeat (20) @(negedge clk);
      check("mrst_stays_idle", {127'd0, busy}, 128'd0);
      check("mrst_core_en", 128'(en_cnt - e0), 128'd0);
      d0 = done_cnt;
      do_start(IV, 5'd2);
      send_block(PT1, CT1);
      send_block(PT2, CT2);
      wait_done(d0, "post_rst");

      // Counter wrap of the low 32 bits
      d0 = done_cnt;
      x0 = xfer_cnt;
      do_start(WIV, 5'd2);
      send_block(PT1, PT1 ^ aes256(KEY, WIV));
`ifdef CTR_OVERFLOW_ERR_EN
      wait_done(d0, "wrap");
      check("wrap_err", {127'd0, err}, 128'd1);
      check("wrap_xfers", 128'(xfer_cnt - x0), 128'd1);
`else
      send_block(PT2, PT2 ^ aes256(KEY, WIV_WRAP));
      wait_done(d0, "wrap");
      check("wrap_err", {127'd0, err}, 128'd0);
      check("wrap_xfers", 128'(xfer_cnt - x0), 128'd2);
`endif

      // Oversized length clamps to 16 blocks; err cleared by the start
      d0 = done_cnt;
      x0 = xfer_cnt;
      do_start(IV, 5'd31);
      check("clamp_err_cleared", {127'd0, err}, 128'd0);
      for (int i = 0; i < 16; i++) begin
         logic [127:0] ctr;
         logic [127:0] d;
         ctr = {IV[127:32], IV[31:0] + 32'(i)};
         d   = {4{32'(i * 32'h01010101)}};
         send_block(d, d ^ aes256(KEY, ctr));
      end
      wait_done(d0, "clamp");
      check("clamp_xfers", 128'(xfer_cnt - x0), 128'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ctr_stream_engine.md
CTR_STREAM_ENGINE -- requirements
Module: ctr_stream_engine

Interface
REQ-001 SHALL have parameter CTR_W, default 32: width of the low IV field that increments per block (1..128).
REQ-002 SHALL have parameter MAX_BLOCKS, default 16: largest message length, in 128-bit blocks.
REQ-003 SHALL have parameter LEN_W, default 5: width of nblocks; LEN_W SHALL satisfy 2^LEN_W > MAX_BLOCKS.
REQ-004 SHALL have port clk, input, 1: clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1: single-cycle message start request.
REQ-007 SHALL have port key, input, 256: AES-256 key, sampled at accepted start.
REQ-008 SHALL have port iv, input, 128: initial counter block, sampled at accepted start.
REQ-009 SHALL have port nblocks, input, LEN_W: message length in blocks, sampled at accepted start.
REQ-010 SHALL have ports din_valid (input, 1), din (input, 128) and din_ready (output, 1): plaintext/ciphertext block stream in.
REQ-011 SHALL have ports dout_valid (output, 1), dout (output, 128) and dout_ready (input, 1): result block stream out.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse) and err (output, 1).

Function
REQ-013 SHALL instantiate the team AES-256 core encryptiontop, driving plaintext with the current counter block, key_i with the latched key, and enable from the engine.
REQ-014 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored with no state change.
REQ-015 SHALL clamp a sampled nblocks greater than MAX_BLOCKS to MAX_BLOCKS.
REQ-016 SHALL use FSM states IDLE, GEN, KS_RDY, OUT and FIN.
REQ-017 Transitions: IDLE->GEN on accepted start with nblocks != 0; IDLE->FIN on accepted start with nblocks == 0, with no core activity.
REQ-018 Transitions: GEN->KS_RDY on the core cipher_counter_o pulse, which SHALL also latch ciphertext into the keystream register.
REQ-019 Transitions: KS_RDY->OUT on the cycle din_valid && din_ready.
REQ-020 Transitions: OUT->GEN on dout_valid && dout_ready when blocks remain; OUT->FIN when the last block is taken.
REQ-021 Transitions: FIN->IDLE unconditionally after one cycle.
REQ-022 Core enable SHALL be 1 only in GEN and SHALL be 0 for at least one cycle between consecutive blocks.
REQ-023 din_ready SHALL be 1 only in KS_RDY.
REQ-024 In KS_RDY the engine SHALL register dout = din XOR keystream; dout SHALL then stay stable until accepted.
REQ-025 dout_valid SHALL be 1 only in OUT; backpressure on dout_ready SHALL hold OUT indefinitely without data loss.
REQ-026 Counter update on each accepted output: counter[CTR_W-1:0] <= counter[CTR_W-1:0] + 1 mod 2^CTR_W; counter[127:CTR_W] SHALL be unchanged.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 done SHALL be 1 exactly in FIN.
REQ-029 err SHALL hold its value until the next accepted start, which clears it.
REQ-030 Encrypt and decrypt SHALL be the same operation; no mode input exists.
REQ-031 din SHALL be ignored outside KS_RDY.

Reset
REQ-032 On rst=1 the FSM SHALL enter IDLE on the next edge, including mid-message.
REQ-033 On reset, busy, done, err, din_ready, dout_valid, core enable and the block count SHALL be 0.
REQ-034 On reset, dout, the keystream register and the counter register SHALL be 0.
REQ-035 rst SHALL take priority over start and all handshakes in the same cycle.
REQ-036 An in-flight core result arriving after reset SHALL be discarded.

Configuration
REQ-037 Macro CTR_OVERFLOW_ERR_EN defined: if an increment would wrap the CTR_W field while blocks remain, the engine SHALL skip further GEN, set err=1 and go OUT->FIN after the current block is accepted.
REQ-038 Macro CTR_OVERFLOW_ERR_EN undefined: the counter SHALL wrap silently and err SHALL be tied to 0.

Verification
REQ-039 Scenario: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, nblocks=2, din 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 -> dout 601ec313775789a5b7a7f504bbf3d228 then f443e3ca4d62b59aca84e990cacaf5c5, then one done pulse.
REQ-040 Scenario: feed the REQ-039 outputs back as din -> original plaintexts are returned.
REQ-041 Scenario: CTR_W=32, iv low word ffffffff, nblocks=2 -> with macro undefined, second counter block low word is 00000000 with upper 96 bits unchanged; with macro defined, exactly one output block, then done with err=1.
REQ-042 Scenario: dout_ready held 0 for 20 cycles in OUT -> dout stable, no core enable, and exactly one block transferred afterwards.
REQ-043 Scenario: nblocks=0 -> done two cycles after start, core enable never asserted; start pulsed while busy -> ignored.
REQ-044 Scenario: rst asserted while in GEN -> next cycle busy=0 and all outputs 0; a new start then produces correct vectors.
